// File: rtl/u_inst_sequencer_pkg.sv
// Shared types and constants for the U-type instruction sequencer.
package u_inst_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'd0,
        TRAP_ILLEGAL = 2'd1,
        TRAP_TIMEOUT = 2'd2
    } trap_cause_t;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    function automatic logic is_u_opcode(input logic [6:0] opcode);
        return (opcode == OPC_LUI) || (opcode == OPC_AUIPC);
    endfunction

endpackage

// File: rtl/u_inst_sequencer_result_unit.sv
// Combinational field extraction and U-type result computation.
module u_result_unit
    import u_inst_sequencer_pkg::*;
(
    input  logic [31:0] ir,
    input  logic [31:0] pc,
    output logic [4:0]  rd,
    output logic [19:0] imm,
    output logic        is_u,
    output logic [31:0] result
);

    logic [6:0]  opcode;
    logic [31:0] upper;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign imm    = ir[31:12];
    assign upper  = {ir[31:12], 12'b0};
    assign is_u   = is_u_opcode(opcode);

    // AUIPC adds the pc of the instruction itself; the sum wraps modulo 2^32.
    assign result = (opcode == OPC_AUIPC) ? (pc + upper) : upper;

endmodule

// File: rtl/u_inst_sequencer.sv
// Multi-cycle LUI/AUIPC sequencer: owns the pc, fetches, computes and writes back,
// and parks in a sticky trap on an illegal opcode or a fetch timeout.
module u_inst_sequencer
    import u_inst_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clear,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_valid,
    input  logic [31:0]      imem_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    input  logic             rf_ack,
    output logic [31:0]      pc_out,
    output logic             busy,
    output logic             halted,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_next;
    logic [31:0]      pc;
    logic [31:0]      ir;
    logic [31:0]      result_q;
    logic [CNT_W-1:0] instret_q;
    trap_cause_t      cause_q;
    logic [TO_W-1:0]  to_cnt;

    logic [4:0]       rd;
    logic [19:0]      unused_imm;
    logic             is_u;
    logic [31:0]      result;
    logic             retire;
    logic             timeout_hit;

    u_result_unit u_result (
        .ir     (ir),
        .pc     (pc),
        .rd     (rd),
        .imm    (unused_imm),
        .is_u   (is_u),
        .result (result)
    );

    // NOTE: sequential state is always written with non-blocking assignments so
    // every register samples the pre-edge values of its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        retire      = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            ST_IDLE:   if (run) state_next = ST_FETCH;
            ST_FETCH: begin
                if (imem_valid) begin
                    state_next = ST_DECODE;
                end else if (to_cnt == TO_LAST) begin
                    state_next  = ST_TRAP;
                    timeout_hit = 1'b1;
                end
            end
            ST_DECODE: state_next = is_u ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                if (rd == 5'd0) retire = 1'b1;
                else            state_next = ST_WB;
            end
            ST_WB:     if (rf_ack) retire = 1'b1;
            ST_TRAP:   if (clear) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        // run is only consulted at retirement so an instruction in flight always completes.
        if (retire) state_next = run ? ST_FETCH : ST_IDLE;
    end

    // NOTE: ir and result_q are ordinary registers, not a memory array, so they
    // are reset like everything else and outputs are defined straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            ir        <= '0;
            result_q  <= '0;
            instret_q <= '0;
            cause_q   <= TRAP_NONE;
            to_cnt    <= '0;
        end else begin
            if (state == ST_FETCH) begin
                if (imem_valid) begin
                    ir     <= imem_rdata;
                    to_cnt <= '0;
                end else if (timeout_hit) begin
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end
            if (timeout_hit)                     cause_q <= TRAP_TIMEOUT;
            if (state == ST_DECODE && !is_u)     cause_q <= TRAP_ILLEGAL;
            if (state == ST_EXEC)                result_q <= result;
            if (retire) begin
                pc        <= pc + 32'd4;
                instret_q <= instret_q + CNT_W'(1);
            end
            if (state == ST_TRAP && clear) begin
                pc      <= RESET_PC;
                cause_q <= TRAP_NONE;
            end
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        rf_we      = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        unique case (state)
            ST_IDLE:   ;
            ST_FETCH:  begin imem_req = 1'b1; busy = 1'b1; end
            ST_DECODE: busy = 1'b1;
            ST_EXEC:   busy = 1'b1;
            ST_WB:     begin rf_we = 1'b1; busy = 1'b1; end
            ST_TRAP:   halted = 1'b1;
            default:   ;
        endcase
        imem_addr  = pc;
        pc_out     = pc;
        rf_waddr   = rd;
        rf_wdata   = result_q;
        trap_cause = cause_q;
        instret    = instret_q;
    end

endmodule

// File: tb/tb_u_inst_sequencer.sv
// Directed self-checking bench for u_inst_sequencer, with a second instance for pc wrap.
module tb_u_inst_sequencer;

    localparam logic [31:0] I_LUI     = 32'h0F56_B6B7;
    localparam logic [31:0] I_AUIPC   = 32'h8B54_9A97;
    localparam logic [31:0] I_LUI_RD0 = 32'h1234_5037;
    localparam logic [31:0] I_ILLEGAL = 32'h0000_0033;

    logic        clk;
    logic        rst_n;
    logic        run, run_w;
    logic        clear;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        rf_ack;

    logic        imem_req,  imem_req_w;
    logic [31:0] imem_addr, imem_addr_w;
    logic        rf_we,     rf_we_w;
    logic [4:0]  rf_waddr,  rf_waddr_w;
    logic [31:0] rf_wdata,  rf_wdata_w;
    logic [31:0] pc_out,    pc_out_w;
    logic        busy,      busy_w;
    logic        halted,    halted_w;
    logic [1:0]  trap_cause, trap_cause_w;
    logic [15:0] instret,   instret_w;

    int errors = 0;
    int checks = 0;

    u_inst_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .clear(clear),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ack(rf_ack),
        .pc_out(pc_out), .busy(busy), .halted(halted),
        .trap_cause(trap_cause), .instret(instret)
    );

    u_inst_sequencer #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(16), .CNT_W(16)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .run(run_w), .clear(clear),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .rf_we(rf_we_w), .rf_waddr(rf_waddr_w), .rf_wdata(rf_wdata_w), .rf_ack(rf_ack),
        .pc_out(pc_out_w), .busy(busy_w), .halted(halted_w),
        .trap_cause(trap_cause_w), .instret(instret_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; run_w = 1'b0; clear = 1'b0;
        imem_valid = 1'b0; imem_rdata = '0; rf_ack = 1'b0;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_rf_we",    32'(rf_we),    32'd0);
        check("rst_pc",       pc_out,        32'h0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_halted",   32'(halted),   32'd0);
        check("rst_cause",    32'(trap_cause), 32'd0);
        check("rst_instret",  32'(instret),  32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // LUI with immediate valid and ack: FETCH, DECODE, EXEC, WB, then FETCH again.
        run = 1'b1; imem_valid = 1'b1; imem_rdata = I_LUI; rf_ack = 1'b1;
        tick();
        check("lui_fetch_req",  32'(imem_req), 32'd1);
        check("lui_fetch_addr", imem_addr,     32'h0);
        check("lui_fetch_busy", 32'(busy),     32'd1);
        tick();
        check("lui_decode_req", 32'(imem_req), 32'd0);
        tick();
        check("lui_exec_we",    32'(rf_we),    32'd0);
        tick();
        check("lui_wb_we",      32'(rf_we),    32'd1);
        check("lui_wb_waddr",   32'(rf_waddr), 32'd13);
        check("lui_wb_wdata",   rf_wdata,      32'h0F56_B000);
        imem_rdata = I_AUIPC;
        tick();
        check("lui_next_fetch", 32'(imem_req), 32'd1);
        check("lui_pc",         pc_out,        32'h4);
        check("lui_instret",    32'(instret),  32'd1);
        check("auipc_addr",     imem_addr,     32'h4);
        rf_ack = 1'b0;

        // AUIPC at pc=4 with ack held off for three WB cycles.
        tick(); tick(); tick();
        check("auipc_wb_we",    32'(rf_we),    32'd1);
        check("auipc_wb_waddr", 32'(rf_waddr), 32'd21);
        check("auipc_wb_wdata", rf_wdata,      32'h8B54_9004);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("auipc_hold_we",    32'(rf_we),    32'd1);
            check("auipc_hold_waddr", 32'(rf_waddr), 32'd21);
            check("auipc_hold_wdata", rf_wdata,      32'h8B54_9004);
        end
        rf_ack = 1'b1; run = 1'b0;
        tick();
        check("auipc_idle_busy", 32'(busy),    32'd0);
        check("auipc_idle_we",   32'(rf_we),   32'd0);
        check("auipc_pc",        pc_out,       32'h8);
        check("auipc_instret",   32'(instret), 32'd2);

        // rd=0 LUI, with run dropped during DECODE: retires without a write, then IDLE.
        run = 1'b1; imem_rdata = I_LUI_RD0;
        tick();
        run = 1'b0;
        tick();
        check("rd0_decode_we", 32'(rf_we), 32'd0);
        tick();
        check("rd0_exec_we",   32'(rf_we), 32'd0);
        tick();
        check("rd0_idle_busy", 32'(busy),    32'd0);
        check("rd0_idle_we",   32'(rf_we),   32'd0);
        check("rd0_pc",        pc_out,       32'hC);
        check("rd0_instret",   32'(instret), 32'd3);

        // Valid arriving on the last counted FETCH cycle is taken, not trapped.
        imem_valid = 1'b0; imem_rdata = I_LUI; run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("late_still_fetch", 32'(imem_req), 32'd1);
        check("late_no_trap0",    32'(halted),   32'd0);
        imem_valid = 1'b1;
        tick();
        check("late_no_trap1",    32'(halted),   32'd0);
        check("late_decode_busy", 32'(busy),     32'd1);
        check("late_decode_req",  32'(imem_req), 32'd0);
        tick(); tick();
        check("late_wb_we", 32'(rf_we), 32'd1);
        tick();
        check("late_pc",      pc_out,       32'h10);
        check("late_instret", 32'(instret), 32'd4);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_idle_pc",     pc_out,       32'h10);
        check("clear_idle_halted", 32'(halted),  32'd0);

        // Illegal opcode: trap with cause 1, pc held, no write; clear restores RESET_PC.
        imem_rdata = I_ILLEGAL; run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        check("ill_decode_we", 32'(rf_we), 32'd0);
        tick();
        check("ill_halted", 32'(halted),     32'd1);
        check("ill_cause",  32'(trap_cause), 32'd1);
        check("ill_pc",     pc_out,          32'h10);
        check("ill_we",     32'(rf_we),      32'd0);
        check("ill_busy",   32'(busy),       32'd0);
        tick();
        check("ill_sticky", 32'(trap_cause), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("ill_clr_halted",  32'(halted),     32'd0);
        check("ill_clr_cause",   32'(trap_cause), 32'd0);
        check("ill_clr_pc",      pc_out,          32'h0);
        check("ill_clr_instret", 32'(instret),    32'd4);

        // Fetch timeout: 16 FETCH cycles without valid trap with cause 2.
        imem_valid = 1'b0; run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("to_not_yet", 32'(halted), 32'd0);
        tick();
        check("to_halted", 32'(halted),     32'd1);
        check("to_cause",  32'(trap_cause), 32'd2);
        check("to_req",    32'(imem_req),   32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("to_clr_cause", 32'(trap_cause), 32'd0);

        // Asynchronous reset while in WB.
        imem_valid = 1'b1; imem_rdata = I_LUI; rf_ack = 1'b0; run = 1'b1;
        tick(); tick(); tick(); tick();
        check("arst_pre_we", 32'(rf_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_we",      32'(rf_we),    32'd0);
        check("arst_busy",    32'(busy),     32'd0);
        check("arst_instret", 32'(instret),  32'd0);
        check("arst_wdata",   rf_wdata,      32'h0);
        check("arst_waddr",   32'(rf_waddr), 32'd0);
        check("arst_req",     32'(imem_req), 32'd0);
        run = 1'b0;
        tick();
        rst_n = 1'b1;

        // pc wrap on the FFFF_FFFC instance; the main instance sees stray valid while idle.
        imem_valid = 1'b1; imem_rdata = I_LUI_RD0; rf_ack = 1'b1; run_w = 1'b1;
        check("wrap_rst_pc", pc_out_w, 32'hFFFF_FFFC);
        tick();
        check("wrap_fetch_addr", imem_addr_w, 32'hFFFF_FFFC);
        run_w = 1'b0;
        tick(); tick(); tick();
        check("wrap_pc",      pc_out_w,       32'h0);
        check("wrap_instret", 32'(instret_w), 32'd1);
        check("wrap_busy",    32'(busy_w),    32'd0);
        check("stray_main_req", 32'(imem_req), 32'd0);
        check("stray_main_pc",  pc_out,        32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
